// File: rtl/dmem_sb_pkg.sv
// dmem_sb_pkg: shared widths and entry type for the data-memory store buffer
package dmem_sb_pkg;
    localparam int SB_AW = 32;
    localparam int SB_DEPTH = 4;
    localparam int PTR_W = $clog2(SB_DEPTH) + 1;
    typedef struct packed {
        logic [SB_AW-3:0] word;
        logic [31:0]      data;
    } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: finds the youngest valid buffered store whose word address matches a load
// Ports: ent/valid (entry array and occupancy mask), head (write index),
//        word (load word address) -> hit, data (youngest matching entry's data)
module sb_fwd_match
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int IW = $clog2(DEPTH)
) (
    input  sb_entry_t        ent [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [IW-1:0]    head,
    input  logic [SB_AW-3:0] word,
    output logic             hit,
    output logic [31:0]      data
);
    logic [IW-1:0] idx;
    // walk oldest to youngest so the last match standing is the youngest
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = head - IW'(k);
            if (valid[idx] && ent[idx].word == word) begin
                hit = 1'b1;
                data = ent[idx].data;
            end
        end
    end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between the core data port and a slow req/ack data RAM
// Ports: clk, reset (async, active-high); core side we/a/wd/rd; status full/empty/overflow;
//        drain side mem_req/mem_addr/mem_wdata/mem_ack; load side mem_raddr/mem_rdata.
// Build option: DMEM_SB_FORWARD_EN adds youngest-match load forwarding from the buffer.
module dmem_store_buffer
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    sb_entry_t     ent [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          enq, deq;

    assign empty = wptr == rptr;
    assign full = wptr[IW-1:0] == rptr[IW-1:0] && wptr[IW] != rptr[IW];
    assign mem_req = ~empty;
    assign deq = mem_req & mem_ack;
    // a drain in the same cycle frees the slot the incoming store needs
    assign enq = we & (~full | mem_ack);
    assign mem_addr = {ent[rptr[IW-1:0]].word, 2'b00};
    assign mem_wdata = ent[rptr[IW-1:0]].data;
    assign mem_raddr = a;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            if (we && !enq) overflow <= 1'b1;
        end

    always_ff @(posedge clk)
        if (enq) ent[wptr[IW-1:0]] <= '{word: a[AW-1:2], data: wd};

`ifdef DMEM_SB_FORWARD_EN
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    count;
    logic             hit;
    logic [31:0]      fwd_data;

    assign count = wptr - rptr;
    // entry i is occupied when its distance past the read index is below the occupancy
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++)
            valid[i] = {1'b0, IW'(i) - rptr[IW-1:0]} < count;
    end

    sb_fwd_match #(.DEPTH(DEPTH), .IW(IW)) u_fwd (
        .ent(ent),
        .valid(valid),
        .head(wptr[IW-1:0]),
        .word(a[AW-1:2]),
        .hit(hit),
        .data(fwd_data)
    );

    assign rd = hit ? fwd_data : mem_rdata;
`else
    assign rd = mem_rdata;
`endif
endmodule
